// File: rtl/mem_rf.sv
// Multi-read-port register file with bit-masked writes and a self-clearing sweep.
// Optional macro MEM_RF_BYPASS_EN selects write-first reads on a same-cycle address match.
module mem_rf #(
  parameter int ADDR_SIZE = 4,
  parameter int BYTE_SIZE = 8,
  parameter int NUM_READ  = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wen,
  input  logic [ADDR_SIZE-1:0]          waddr,
  input  logic [BYTE_SIZE-1:0]          wdata,
  input  logic [BYTE_SIZE-1:0]          wmask,
  input  logic [NUM_READ-1:0]           ren,
  input  logic [NUM_READ*ADDR_SIZE-1:0] raddr,
  output logic [NUM_READ*BYTE_SIZE-1:0] rdata,
  output logic [NUM_READ-1:0]           rvalid,
  input  logic                          clear,
  output logic                          busy
);

  localparam int DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_SIZE-1:0]          clr_addr_q, clr_addr_d;
  logic [NUM_READ*BYTE_SIZE-1:0] rdata_q, rdata_d;
  logic [NUM_READ-1:0]           rvalid_q, rvalid_d;

  logic [BYTE_SIZE-1:0] mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [BYTE_SIZE-1:0] mem_wdata;
  logic [BYTE_SIZE-1:0] merged;
  logic [ADDR_SIZE-1:0] ra;

  assign merged = (mem_q[waddr] & ~wmask) | (wdata & wmask);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = merged;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    ra         = '0;
    case (state_q)
      S_CLEAR: begin
        // One zero write per cycle; all user requests are ignored here.
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_SIZE'(1);
        end
      end
      default: begin
        // Clear wins over a same-cycle write; reads are still served.
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else begin
          mem_we = wen;
        end
        for (int i = 0; i < NUM_READ; i++) begin
          if (ren[i]) begin
            ra          = raddr[i*ADDR_SIZE +: ADDR_SIZE];
            rvalid_d[i] = 1'b1;
`ifdef MEM_RF_BYPASS_EN
            if (mem_we && (ra == waddr)) begin
              rdata_d[i*BYTE_SIZE +: BYTE_SIZE] = merged;
            end else begin
              rdata_d[i*BYTE_SIZE +: BYTE_SIZE] = mem_q[ra];
            end
`else
            rdata_d[i*BYTE_SIZE +: BYTE_SIZE] = mem_q[ra];
`endif
          end
        end
      end
    endcase
  end

  // Reset lands in CLEAR so the array is always swept before first use.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q == S_CLEAR);

endmodule

// File: tb/tb_mem_rf.sv
// Directed bench for mem_rf at ADDR_SIZE=2, BYTE_SIZE=3, NUM_READ=2.
module tb_mem_rf;
  localparam int AW = 2;
  localparam int BW = 3;
  localparam int NR = 2;

  logic          clock;
  logic          reset_n;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [BW-1:0] wdata;
  logic [BW-1:0] wmask;
  logic [NR-1:0] ren;
  logic [NR*AW-1:0] raddr;
  logic [NR*BW-1:0] rdata;
  logic [NR-1:0] rvalid;
  logic          clear;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_busy;

`ifdef MEM_RF_BYPASS_EN
  localparam logic [BW-1:0] COLL_EXP = 3'd6;
`else
  localparam logic [BW-1:0] COLL_EXP = 3'd1;
`endif

  mem_rf #(.ADDR_SIZE(AW), .BYTE_SIZE(BW), .NUM_READ(NR)) dut (
    .clock(clock), .reset_n(reset_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .clear(clear), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [BW-1:0] m);
    wen = 1'b1; waddr = a; wdata = d; wmask = m;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ren = en; raddr = {a1, a0};
    tick();
    ren = '0;
  endtask

  task automatic count_busy(input string tag);
    n_busy = 0;
    while (busy && n_busy < 20) begin
      tick();
      n_busy++;
    end
    check(tag, n_busy, 4);
  endtask

  initial begin
    reset_n = 1'b1; wen = 0; waddr = 0; wdata = 0; wmask = 0;
    ren = 0; raddr = 0; clear = 0;
    #2 reset_n = 1'b0;
    #2;
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 1);
    @(posedge clock); #1 reset_n = 1'b1;
    count_busy("rst_busy_len");

    for (int a = 0; a < 4; a++) begin
      rd(2'b11, AW'(a), AW'(3 - a));
      check("init_rvalid", rvalid, 2'b11);
      check("init_rdata", rdata, 0);
    end
    tick();
    check("idle_rvalid", rvalid, 0);

    // write/read on both ports
    wr(2'd2, 3'd5, 3'd7);
    rd(2'b11, 2'd2, 2'd2);
    check("wr_rvalid", rvalid, 2'b11);
    check("wr_rdata", rdata, {3'd5, 3'd5});
    tick();
    check("hold_rvalid", rvalid, 0);
    check("hold_rdata", rdata, {3'd5, 3'd5});

    // bit mask: 7 with bit1 cleared -> 5; port1 holds its old value
    wr(2'd1, 3'd7, 3'd7);
    wr(2'd1, 3'd0, 3'b010);
    rd(2'b01, 2'd1, 2'd0);
    check("mask_rvalid", rvalid, 2'b01);
    check("mask_rdata", rdata, {3'd5, 3'd5});
    wr(2'd1, 3'd2, 3'b011);
    rd(2'b10, 2'd0, 2'd1);
    check("mask2_rdata", rdata, {3'd6, 3'd5});

    // same-cycle read/write collision
    wr(2'd3, 3'd1, 3'd7);
    wen = 1'b1; waddr = 2'd3; wdata = 3'd6; wmask = 3'd7;
    rd(2'b11, 2'd3, 2'd3);
    wen = 1'b0;
    check("coll_rdata", rdata, {COLL_EXP, COLL_EXP});
    rd(2'b11, 2'd3, 2'd3);
    check("coll_after", rdata, {3'd6, 3'd6});

    // clear with a simultaneous write, requests hammered during the sweep
    for (int a = 0; a < 4; a++) wr(AW'(a), 3'd7, 3'd7);
    clear = 1'b1; wen = 1'b1; waddr = 2'd0; wdata = 3'd2; wmask = 3'd7;
    tick();
    ren = 2'b11; raddr = {2'd3, 2'd0}; waddr = 2'd3; wdata = 3'd7;
    n_busy = 0;
    while (busy && n_busy < 20) begin
      tick();
      n_busy++;
      check("clr_rvalid", rvalid, 0);
      check("clr_rdata_hold", rdata, {3'd6, 3'd6});
    end
    check("clr_busy_len", n_busy, 4);
    clear = 1'b0; wen = 1'b0; ren = 2'b00;
    for (int a = 0; a < 4; a++) begin
      rd(2'b11, AW'(a), AW'(a));
      check("clr_rdata", rdata, 0);
      check("clr_rvalid_after", rvalid, 2'b11);
    end

    // reset during the second clear cycle
    wr(2'd2, 3'd5, 3'd7);
    clear = 1'b1; ren = 2'b11; raddr = {2'd2, 2'd2};
    tick();
    clear = 1'b0; ren = 2'b00;
    check("msw_read", rdata, {3'd5, 3'd5});
    check("msw_busy", busy, 1);
    tick();
    check("msw_hold", rdata, {3'd5, 3'd5});
    check("msw_rvalid", rvalid, 0);
    #2 reset_n = 1'b0;
    #1;
    check("msw_rst_rdata", rdata, 0);
    check("msw_rst_rvalid", rvalid, 0);
    check("msw_rst_busy", busy, 1);
    @(posedge clock); #1 reset_n = 1'b1;
    count_busy("msw_busy_len");
    rd(2'b11, 2'd2, 2'd1);
    check("msw_rdata_after", rdata, 0);
    check("msw_rvalid_after", rvalid, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_rf.md
MEM_RF -- requirements
Module: mem_rf

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, address width; depth DEPTH = 2**ADDR_SIZE words.
REQ-002 SHALL have parameter BYTE_SIZE, default 8, word width in bits.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports (1..8).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wen  input  1  write request.
REQ-007 SHALL have port waddr  input  ADDR_SIZE  write address.
REQ-008 SHALL have port wdata  input  BYTE_SIZE  write data.
REQ-009 SHALL have port wmask  input  BYTE_SIZE  per-bit write enable; only bits at 1 are updated.
REQ-010 SHALL have port ren  input  NUM_READ  per-port read request.
REQ-011 SHALL have port raddr  input  NUM_READ*ADDR_SIZE  packed read addresses; port i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-012 SHALL have port rdata  output  NUM_READ*BYTE_SIZE  packed registered read data, same packing.
REQ-013 SHALL have port rvalid  output  NUM_READ  per-port read-data valid, one cycle pulse.
REQ-014 SHALL have port clear  input  1  request to zero the whole array.
REQ-015 SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-016 SHALL store DEPTH words; every address 0..DEPTH-1 is addressable, no aliasing.
REQ-017 SHALL, in IDLE with wen=1, update mem[waddr] = (mem[waddr] & ~wmask) | (wdata & wmask) at the clock edge.
REQ-018 SHALL, for each port i in IDLE with ren[i]=1, present mem[raddr_i] on rdata_i and assert rvalid[i] exactly one cycle later (latency 1).
REQ-019 SHALL hold rdata_i unchanged and drive rvalid[i]=0 when ren[i]=0 in the prior cycle.
REQ-020 SHALL allow all read ports to access the same or different addresses in the same cycle without conflict.
REQ-021 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clear=1; CLEAR->IDLE after the cycle writing address DEPTH-1.
REQ-022 SHALL, in CLEAR, write 0 to one address per cycle, ascending from 0, taking exactly DEPTH cycles; busy=1 throughout CLEAR.
REQ-023 SHALL ignore wen, ren and clear while busy=1; rvalid=0 during CLEAR and rdata holds.
REQ-024 SHALL treat clear=1 and wen=1 in the same IDLE cycle as clear only; the write is dropped.
REQ-025 SHALL wrap the clear address counter only by FSM exit; no counter overflow past DEPTH-1 is observable.

Reset
REQ-026 SHALL, on reset_n=0, asynchronously force rdata=0, rvalid=0, and FSM to CLEAR with clear address 0, busy=1.
REQ-027 SHALL, on reset_n rising, run a full DEPTH-cycle clear sweep before accepting any access.
REQ-028 SHALL restart the sweep from address 0 if reset_n asserts mid-sweep or mid-operation.

Configuration
REQ-029 SHALL support macro MEM_RF_BYPASS_EN.
REQ-030 SHALL, with MEM_RF_BYPASS_EN defined, return for a read of raddr_i==waddr in a cycle with wen=1 the post-write merged word (write-first).
REQ-031 SHALL, without MEM_RF_BYPASS_EN, return the pre-write word in that case (read-first); all other behaviour identical.

Verification (ADDR_SIZE=2, BYTE_SIZE=3, NUM_READ=2 unless noted)
REQ-032 SHALL cover reset release: busy=1 for exactly 4 cycles, then reads of addresses 0..3 on both ports -> rdata 0, rvalid=1 one cycle after ren.
REQ-033 SHALL cover write/read: write 5 to addr 2 with wmask=7, next cycle ren=2'b11 raddr both 2 -> both rdata=5 one cycle later.
REQ-034 SHALL cover mask: addr 1 holds 7, write wdata=0 wmask=3'b010 -> subsequent read returns 5.
REQ-035 SHALL cover same-cycle collision: addr 3 holds 1, write 6 to addr 3 while reading addr 3 -> rdata 6 with MEM_RF_BYPASS_EN, 1 without.
REQ-036 SHALL cover clear: fill all addresses with 7, pulse clear with wen=1 to addr 0 data 2 -> busy 4 cycles, write dropped, all reads then return 0.
REQ-037 SHALL cover reset mid-sweep: assert reset_n=0 on second CLEAR cycle -> rdata/rvalid 0 immediately, busy again exactly 4 cycles after release.
